// File: rtl/arith_mul_stall_pipe.sv
// Pipelined RV64M multiplier FU with per-stage stall, bubble collapse and occupancy count.
// Shared issue/writeback record types live in the package at the top of this file.
package arith_mul_pkg;
  localparam int FU_XLEN = 64;

  localparam logic [2:0] OP_MUL    = 3'd0;
  localparam logic [2:0] OP_MULH   = 3'd1;
  localparam logic [2:0] OP_MULHSU = 3'd2;
  localparam logic [2:0] OP_MULHU  = 3'd3;
  localparam logic [2:0] OP_MULW   = 3'd4;

  typedef struct packed {
    logic [2:0] mul;
  } fu_op_t;

  typedef struct packed {
    logic [63:0]        pc;
    logic [7:0]         id;
    logic [6:0]         prd;
    logic [FU_XLEN-1:0] rs1val;
    logic [FU_XLEN-1:0] rs2val;
    fu_op_t             op;
  } fu_input_t;

  typedef struct packed {
    logic [63:0]        pc;
    logic [7:0]         id;
    logic [6:0]         prd;
    logic [FU_XLEN-1:0] rdval;
  } fu_output_t;
endpackage

module arith_mul_stall_pipe
  import arith_mul_pkg::*;
#(
  parameter int XLEN = 64,
  parameter int PIPE_DEPTH = 3,
  localparam int OCC_W = $clog2(PIPE_DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rstn,
  input  fu_input_t        fuinput_i,
  input  logic             fuinput_i_valid,
  output logic             fuinput_i_ready,
  output fu_output_t       fuoutput_o,
  output logic             fuoutput_o_valid,
  input  logic             fuoutput_o_ready,
  input  logic             squash,
  output logic [OCC_W-1:0] occ_o
);

  typedef struct packed {
    logic [63:0]         pc;
    logic [7:0]          id;
    logic [6:0]          prd;
    logic [2:0]          op;
    logic [2*XLEN-1:0]   prod;
  } stage_t;

  logic [XLEN-1:0]     op_a, op_b;
  logic                sign_a, sign_b;
  logic [2*XLEN-1:0]   ext_a, ext_b, prod;
  logic [PIPE_DEPTH:1] vld, adv;
  stage_t              st [1:PIPE_DEPTH];
  logic                accept, fire;
  logic [OCC_W-1:0]    occ_q;
  logic [XLEN-1:0]     res;

  // The extra sign bit folded into a 2*XLEN extension gives the right product modulo 2^(2*XLEN).
  always_comb begin
    op_a = fuinput_i.rs1val[XLEN-1:0];
    op_b = fuinput_i.rs2val[XLEN-1:0];
    if (fuinput_i.op.mul == OP_MULW) begin
      op_a = XLEN'($signed(fuinput_i.rs1val[31:0]));
      op_b = XLEN'($signed(fuinput_i.rs2val[31:0]));
    end
    sign_a = ((fuinput_i.op.mul == OP_MULH) || (fuinput_i.op.mul == OP_MULHSU)) & op_a[XLEN-1];
    sign_b = (fuinput_i.op.mul == OP_MULH) & op_b[XLEN-1];
    ext_a  = {{XLEN{sign_a}}, op_a};
    ext_b  = {{XLEN{sign_b}}, op_b};
    prod   = ext_a * ext_b;
  end

  // A stage may load when it is empty or anything downstream of it can make room.
  always_comb begin : adv_chain
    logic go;
    go = !vld[PIPE_DEPTH] | fuoutput_o_ready;
    adv = '0;
    adv[PIPE_DEPTH] = go;
    for (int k = PIPE_DEPTH - 1; k >= 1; k--) begin
      go = !vld[k] | go;
      adv[k] = go;
    end
  end

  assign fuinput_i_ready  = adv[1] & !squash;
  assign accept           = fuinput_i_valid & fuinput_i_ready;
  assign fire             = vld[PIPE_DEPTH] & fuoutput_o_ready;
  assign fuoutput_o_valid = vld[PIPE_DEPTH];
  assign occ_o            = occ_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      vld <= '0;
    end else if (squash) begin
      vld <= '0;
    end else begin
      if (adv[1]) vld[1] <= accept;
      for (int k = 2; k <= PIPE_DEPTH; k++) begin
        if (adv[k]) vld[k] <= vld[k-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      st[1].pc   <= fuinput_i.pc;
      st[1].id   <= fuinput_i.id;
      st[1].prd  <= fuinput_i.prd;
      st[1].op   <= fuinput_i.op.mul;
      st[1].prod <= prod;
    end
    for (int k = 2; k <= PIPE_DEPTH; k++) begin
      if (adv[k] && vld[k-1]) st[k] <= st[k-1];
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      occ_q <= '0;
    end else if (squash) begin
      occ_q <= '0;
    end else begin
      occ_q <= occ_q + OCC_W'(accept) - OCC_W'(fire);
    end
  end

  always_comb begin
    res = '0;
    case (st[PIPE_DEPTH].op)
      OP_MUL:                         res = st[PIPE_DEPTH].prod[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU:   res = st[PIPE_DEPTH].prod[2*XLEN-1:XLEN];
      OP_MULW:                        res = XLEN'($signed(st[PIPE_DEPTH].prod[31:0]));
      default:                        res = '0;
    endcase
    fuoutput_o       = '0;
    fuoutput_o.pc    = st[PIPE_DEPTH].pc;
    fuoutput_o.id    = st[PIPE_DEPTH].id;
    fuoutput_o.prd   = st[PIPE_DEPTH].prd;
    fuoutput_o.rdval = FU_XLEN'(res);
  end

endmodule

// File: tb/tb_arith_mul_stall_pipe.sv
// Self-checking bench for arith_mul_stall_pipe: directed scenarios then randomized traffic
// against an in-order scoreboard whose results come from plain 128-bit arithmetic.
module tb_arith_mul_stall_pipe;
  import arith_mul_pkg::*;

  localparam int PD = 3;

  logic       clk = 1'b0;
  logic       rstn;
  fu_input_t  fuIn;
  logic       inValid, inReady;
  fu_output_t fuOut;
  logic       outValid, outReady, squash;
  logic [1:0] occ;

  fu_output_t expQ[$];
  int         vectorCount = 0;
  int         missCount = 0;
  logic [7:0] nextId = 8'd0;
  logic       lastValid, lastAccept, lastFire, lastReady;
  logic [1:0] lastOcc;
  logic [63:0] lastRdval;

  always #5 clk = ~clk;

  arith_mul_stall_pipe #(.XLEN(64), .PIPE_DEPTH(PD)) dut (
    .clk(clk),
    .rstn(rstn),
    .fuinput_i(fuIn),
    .fuinput_i_valid(inValid),
    .fuinput_i_ready(inReady),
    .fuoutput_o(fuOut),
    .fuoutput_o_valid(outValid),
    .fuoutput_o_ready(outReady),
    .squash(squash),
    .occ_o(occ)
  );

  // Reference result straight from the ISA definitions using full 128-bit products.
  function automatic logic [63:0] refResult(logic [2:0] op, logic [63:0] x, logic [63:0] y);
    logic [127:0] sx, sy, ux, uy, p;
    logic [31:0]  w;
    logic [63:0]  r;
    sx = {{64{x[63]}}, x};
    sy = {{64{y[63]}}, y};
    ux = {64'd0, x};
    uy = {64'd0, y};
    r = 64'd0;
    p = 128'd0;
    w = 32'd0;
    case (op)
      OP_MUL:    begin p = ux * uy; r = p[63:0];   end
      OP_MULH:   begin p = sx * sy; r = p[127:64]; end
      OP_MULHSU: begin p = sx * uy; r = p[127:64]; end
      OP_MULHU:  begin p = ux * uy; r = p[127:64]; end
      OP_MULW:   begin w = x[31:0] * y[31:0]; r = {{32{w[31]}}, w}; end
      default:   r = 64'd0;
    endcase
    return r;
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    vectorCount++;
    assert (observed === expected) else begin
      missCount++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // One clock cycle: drive at the negedge, check 1 time unit later, update the model at the posedge.
  task automatic applyStimulus(input logic v, input logic [2:0] op, input logic [63:0] r1,
                               input logic [63:0] r2, input logic rdy, input logic sq);
    fu_output_t head;
    fu_output_t item;
    fuIn.pc     = {$urandom, $urandom};
    fuIn.id     = nextId;
    fuIn.prd    = 7'($urandom);
    fuIn.rs1val = r1;
    fuIn.rs2val = r2;
    fuIn.op.mul = op;
    inValid  = v;
    outReady = rdy;
    squash   = sq;
    #1;
    checkOutput("ready", 64'(inReady), 64'(!sq && ((expQ.size() < PD) || rdy)));
    checkOutput("occ", 64'(occ), 64'(expQ.size()));
    if (expQ.size() == 0) begin
      checkOutput("idleValid", 64'(outValid), 64'd0);
    end else if (outValid) begin
      head = expQ[0];
      checkOutput("outPc", fuOut.pc, head.pc);
      checkOutput("outId", 64'(fuOut.id), 64'(head.id));
      checkOutput("outPrd", 64'(fuOut.prd), 64'(head.prd));
      checkOutput("outRdval", fuOut.rdval, head.rdval);
    end
    lastValid  = outValid;
    lastReady  = inReady;
    lastOcc    = occ;
    lastRdval  = fuOut.rdval;
    lastAccept = v & inReady;
    lastFire   = outValid & rdy;
    if (lastFire && (expQ.size() > 0)) void'(expQ.pop_front());
    if (lastAccept) begin
      item.pc    = fuIn.pc;
      item.id    = fuIn.id;
      item.prd   = fuIn.prd;
      item.rdval = refResult(op, r1, r2);
      expQ.push_back(item);
      nextId++;
    end
    @(posedge clk);
    if (sq) expQ.delete();
    @(negedge clk);
  endtask

  task automatic runOne(input string tag, input logic [2:0] op, input logic [63:0] r1,
                        input logic [63:0] r2, input logic [63:0] want);
    int waited;
    waited = 0;
    applyStimulus(1'b1, op, r1, r2, 1'b1, 1'b0);
    do begin
      applyStimulus(1'b0, OP_MUL, 64'd0, 64'd0, 1'b1, 1'b0);
      waited++;
    end while (!lastValid && (waited < 10));
    checkOutput({tag, "Latency"}, 64'(waited), 64'd3);
    checkOutput(tag, lastRdval, want);
  endtask

  initial begin
    int pending, fires, firstFire, lastFireCyc, emitted;
    logic [63:0] r1, r2;
    rstn     = 1'b0;
    fuIn     = '0;
    inValid  = 1'b0;
    outReady = 1'b0;
    squash   = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    checkOutput("rstValid", 64'(outValid), 64'd0);
    checkOutput("rstOcc", 64'(occ), 64'd0);
    checkOutput("rstReady", 64'(inReady), 64'd1);
    @(negedge clk);
    rstn = 1'b1;

    // Directed result and latency checks.
    runOne("mulNeg", OP_MUL, 64'd3, 64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFA);
    runOne("mulhu", OP_MULHU, '1, '1, 64'hFFFF_FFFF_FFFF_FFFE);
    runOne("mulh", OP_MULH, '1, '1, 64'd0);
    runOne("mulhsu", OP_MULHSU, '1, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF);
    runOne("mulw", OP_MULW, 64'hDEAD_BEEF_7FFF_FFFF, 64'h1234_5678_0000_0002, 64'hFFFF_FFFF_FFFF_FFFE);
    runOne("badOp", 3'd6, 64'd5, 64'd7, 64'd0);

    // Backpressure: fill, stall, then drain in order at one result per cycle.
    pending = 0; fires = 0; firstFire = -1; lastFireCyc = -1;
    for (int c = 0; (c < 30) && ((pending < 5) || (expQ.size() > 0)); c++) begin
      applyStimulus(pending < 5, OP_MUL, {$urandom, $urandom}, {$urandom, $urandom}, c >= 5, 1'b0);
      if (lastAccept) pending++;
      if (lastFire) begin
        fires++;
        if (firstFire < 0) firstFire = c;
        lastFireCyc = c;
      end
      if (c == 3) begin
        checkOutput("fullOcc", 64'(lastOcc), 64'd3);
        checkOutput("fullReady", 64'(lastReady), 64'd0);
      end
    end
    checkOutput("b2bFires", 64'(fires), 64'd5);
    checkOutput("b2bSpan", 64'(lastFireCyc - firstFire), 64'd4);
    checkOutput("b2bOccEnd", 64'(occ), 64'd0);

    // Bubble collapse under a stalled output, then squash.
    applyStimulus(1'b1, OP_MULHU, {$urandom, $urandom}, {$urandom, $urandom}, 1'b0, 1'b0);
    applyStimulus(1'b0, OP_MUL, 64'd0, 64'd0, 1'b0, 1'b0);
    checkOutput("bubbleS1", 64'(lastValid), 64'd0);
    applyStimulus(1'b0, OP_MUL, 64'd0, 64'd0, 1'b0, 1'b0);
    checkOutput("bubbleS2", 64'(lastValid), 64'd0);
    applyStimulus(1'b0, OP_MUL, 64'd0, 64'd0, 1'b0, 1'b0);
    checkOutput("bubbleS3", 64'(lastValid), 64'd1);
    applyStimulus(1'b1, OP_MUL, 64'd9, 64'd9, 1'b0, 1'b1);
    checkOutput("squashReady", 64'(lastReady), 64'd0);
    applyStimulus(1'b0, OP_MUL, 64'd0, 64'd0, 1'b0, 1'b0);
    checkOutput("squashValid", 64'(lastValid), 64'd0);
    checkOutput("squashOcc", 64'(lastOcc), 64'd0);

    // Asynchronous reset with a full pipe loses everything.
    for (int i = 0; i < 3; i++)
      applyStimulus(1'b1, OP_MUL, {$urandom, $urandom}, {$urandom, $urandom}, 1'b0, 1'b0);
    inValid = 1'b0;
    rstn = 1'b0;
    #1;
    checkOutput("midRstValid", 64'(outValid), 64'd0);
    checkOutput("midRstOcc", 64'(occ), 64'd0);
    expQ.delete();
    @(negedge clk);
    rstn = 1'b1;
    emitted = 0;
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b0, OP_MUL, 64'd0, 64'd0, 1'b1, 1'b0);
      if (lastValid) emitted++;
    end
    checkOutput("midRstEmitted", 64'(emitted), 64'd0);

    // Randomized traffic with random backpressure, corner operands and occasional squash.
    for (int c = 0; c < 400; c++) begin
      r1 = {$urandom, $urandom};
      r2 = {$urandom, $urandom};
      case ($urandom_range(0, 7))
        0: r1 = '1;
        1: r2 = 64'h8000_0000_0000_0000;
        2: r1 = 64'd0;
        3: r2 = 64'h0000_0000_8000_0000;
        default: ;
      endcase
      applyStimulus($urandom_range(0, 3) != 0, 3'($urandom_range(0, 5)), r1, r2,
                    $urandom_range(0, 2) != 0, $urandom_range(0, 40) == 0);
    end
    for (int c = 0; (c < 20) && (expQ.size() > 0); c++)
      applyStimulus(1'b0, OP_MUL, 64'd0, 64'd0, 1'b1, 1'b0);
    checkOutput("drainEmpty", 64'(expQ.size()), 64'd0);
    checkOutput("drainOcc", 64'(occ), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
    $finish;
  end

endmodule
